// File: rtl/io_sw_debounce.sv
// io_sw_debounce: two-flop synchronizer plus per-bit stability counter for
// the board slide switches. Produces a 32-bit zero-extended switch word for
// the load/store unit.
// Optional edge pulses (sw_rise_o/sw_fall_o/sw_change_o) are built only when
// IO_SW_DEBOUNCE_EDGE_EN is defined; otherwise those outputs are tied to 0.
module io_sw_debounce #(
  parameter int unsigned NUM_SW       = 17,
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_SW-1:0] sw_raw_i,
  output logic [31:0]       io_sw_o,
  output logic [NUM_SW-1:0] sw_rise_o,
  output logic [NUM_SW-1:0] sw_fall_o,
  output logic              sw_change_o
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;
  logic [NUM_SW-1:0] stable_q;
  logic [NUM_SW-1:0] settle;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];

  // Two-flop synchronizer; only sync2_q is used downstream
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // A bit settles when it has differed from stable for DEBOUNCE_CYC cycles
  always_comb begin
    settle = '0;
    for (int unsigned b = 0; b < NUM_SW; b++) begin
      settle[b] = (sync2_q[b] != stable_q[b]) && (cnt_q[b] == CNT_MAX);
    end
  end

  // Per-bit stability counters and debounced levels; counter clears at its
  // terminal value so it can never wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= '0;
      for (int unsigned b = 0; b < NUM_SW; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_SW; b++) begin
        if (sync2_q[b] == stable_q[b]) begin
          cnt_q[b] <= '0;
        end else if (settle[b]) begin
          cnt_q[b]    <= '0;
          stable_q[b] <= sync2_q[b];
        end else begin
          cnt_q[b] <= cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  assign io_sw_o = 32'(stable_q);

`ifdef IO_SW_DEBOUNCE_EDGE_EN
  logic [NUM_SW-1:0] rise_q;
  logic [NUM_SW-1:0] fall_q;

  // Pulses register on the same edge stable updates, so they line up with
  // the first cycle io_sw_o shows the new level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= settle & sync2_q;
      fall_q <= settle & ~sync2_q;
    end
  end

  assign sw_rise_o   = rise_q;
  assign sw_fall_o   = fall_q;
  assign sw_change_o = |{rise_q, fall_q};
`else
  assign sw_rise_o   = '0;
  assign sw_fall_o   = '0;
  assign sw_change_o = 1'b0;
`endif

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce with DEBOUNCE_CYC=4, NUM_SW=17.
// Pulse expectations follow IO_SW_DEBOUNCE_EDGE_EN: zero when undefined.
module tb_io_sw_debounce;

  localparam int unsigned NSW = 17;
  localparam int unsigned DC  = 4;
`ifdef IO_SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [NSW-1:0] raw;
  logic [31:0]    io_sw;
  logic [NSW-1:0] rise;
  logic [NSW-1:0] fall;
  logic           change;

  int unsigned total = 0;
  int unsigned bad   = 0;

  io_sw_debounce #(
    .NUM_SW      (NSW),
    .DEBOUNCE_CYC(DC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sw_raw_i   (raw),
    .io_sw_o    (io_sw),
    .sw_rise_o  (rise),
    .sw_fall_o  (fall),
    .sw_change_o(change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pe(input logic [31:0] v);
    return EDGE ? v : 32'h0;
  endfunction

  task automatic chk_all(input string tag, input logic [31:0] e_io,
                         input logic [31:0] e_rise, input logic [31:0] e_fall);
    chk({tag, ".io"},   io_sw,          e_io);
    chk({tag, ".rise"}, 32'(rise),      pe(e_rise));
    chk({tag, ".fall"}, 32'(fall),      pe(e_fall));
    chk({tag, ".chg"},  32'(change),    pe(32'((e_rise | e_fall) != 0)));
  endtask

  // advance one rising edge, then settle 1ns before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    raw = 17'h1FFFF;

    // reset held 3 cycles with all switches high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 32'h0, 32'h0, 32'h0);
    end
    rst = 1'b0;
    raw = '0;
    repeat (8) tick();
    chk_all("idle", 32'h0, 32'h0, 32'h0);

    // clean rise on bit 0: visible on the 6th edge
    raw[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("b0_wait", 32'h0, 32'h0, 32'h0);
    end
    tick();
    chk_all("b0_set", 32'h1, 32'h1, 32'h0);
    tick();
    chk_all("b0_after", 32'h1, 32'h0, 32'h0);

    // 3-cycle glitch on bit 3 is rejected
    raw[3] = 1'b1;
    repeat (3) tick();
    raw[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_all("glitch3", 32'h1, 32'h0, 32'h0);
    end

    // bounce on bit 5: 1,0,1,1,0,1,1,1,1 then held
    begin
      logic [8:0] pat;
      pat = 9'b111101101; // index 0 in LSB
      for (int i = 0; i < 9; i++) begin
        raw[5] = pat[i];
        tick();
        chk_all("bounce5", 32'h1, 32'h0, 32'h0);
      end
    end
    tick();
    chk_all("bounce5_e5", 32'h1, 32'h0, 32'h0);
    tick();
    chk_all("bounce5_set", 32'h21, 32'h20, 32'h0);
    tick();
    chk_all("bounce5_after", 32'h21, 32'h0, 32'h0);

    // release all: simultaneous falls on bits 0 and 5
    raw = '0;
    repeat (5) tick();
    chk_all("fall_e5", 32'h21, 32'h0, 32'h0);
    tick();
    chk_all("fall_set", 32'h0, 32'h0, 32'h21);
    tick();
    chk_all("fall_after", 32'h0, 32'h0, 32'h0);

    // bits 0 and 16 together settle in the same cycle
    raw = 17'h10001;
    repeat (5) tick();
    chk_all("dual_e5", 32'h0, 32'h0, 32'h0);
    tick();
    chk_all("dual_set", 32'h00010001, 32'h10001, 32'h0);
    tick();
    chk_all("dual_after", 32'h00010001, 32'h0, 32'h0);

    // reset at count=2 on bit 1 discards the count; no pulse from reset
    raw[1] = 1'b1;
    repeat (4) tick();
    chk_all("mid_pre", 32'h00010001, 32'h0, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all("mid_rst", 32'h0, 32'h0, 32'h0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all("post_rst_wait", 32'h0, 32'h0, 32'h0);
    end
    tick();
    chk_all("post_rst_set", 32'h00010003, 32'h10003, 32'h0);
    tick();
    chk_all("post_rst_after", 32'h00010003, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
